// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst read/write controller in front of a single-port
// DEPTH x DATA_W word array. One request carries a start address and a beat
// count. Write beats are paced by data_valid. Read beats stream out one per
// cycle with a one-cycle registered latency.
// Optional feature: define MEM_BURST_PARITY_EN to store an even-parity bit
// with every word. This adds the par_inj input and the par_err output.
module mem_burst_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int BLEN_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              wr_rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BLEN_W-1:0] burst_len,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
`ifdef MEM_BURST_PARITY_EN
  input  logic              par_inj,
  output logic              par_err,
`endif
  output logic              busy
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef MEM_BURST_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [BLEN_W-1:0] beats_left_q, beats_left_d;
  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q, rd_valid_d;
  logic              mem_we;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;

  // Storage is not reset so that an aborted burst leaves earlier beats intact.
  logic [MEM_W-1:0]  mem_q [DEPTH];

`ifdef MEM_BURST_PARITY_EN
  logic par_err_q;
  // The stored bit makes the word's XOR zero. par_inj flips it to test the checker.
  assign wr_word = {(^data_in) ^ par_inj, data_in};
`else
  assign wr_word = data_in;
`endif

  assign rd_word = mem_q[cur_addr_q];

  // Burst sequencing. Both beat states share the address and count update.
  // The beat that sees beats_left == 0 is the last one and returns to IDLE.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    mem_we       = 1'b0;
    rd_valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cur_addr_d   = addr;
          beats_left_d = burst_len;
          state_d      = wr_rd ? WRITE : READ;
        end
      end
      WRITE: begin
        if (data_valid) begin
          mem_we     = 1'b1;
          cur_addr_d = cur_addr_q + 1'b1;
          if (beats_left_q == '0) state_d = IDLE;
          else                    beats_left_d = beats_left_q - 1'b1;
        end
      end
      READ: begin
        rd_valid_d = 1'b1;
        cur_addr_d = cur_addr_q + 1'b1;
        if (beats_left_q == '0) state_d = IDLE;
        else                    beats_left_d = beats_left_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and registered read port. data_out holds between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      data_out_q   <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      rd_valid_q   <= rd_valid_d;
      if (rd_valid_d) data_out_q <= rd_word[DATA_W-1:0];
    end
  end

`ifdef MEM_BURST_PARITY_EN
  // The parity flag travels with the read beat and is low when no beat is present.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_err_q <= 1'b0;
    else      par_err_q <= rd_valid_d & (^rd_word);
  end
  assign par_err = par_err_q;
`endif

  // Single-port array write. Only a write beat ever enables it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[cur_addr_q] <= wr_word;
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rd_valid  = rd_valid_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl. Expected read beats come from a
// shadow memory. They are queued when a read is issued and popped by a monitor.
// Parity checks are active only when MEM_BURST_PARITY_EN is defined.
module tb_mem_burst_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, wr_rd, data_valid, rd_valid, busy;
  logic [5:0] addr;
  logic [3:0] burst_len;
  logic [7:0] data_in, data_out;
  logic       par_inj, par_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model_mem [64];
  logic       model_pe  [64];
  logic [8:0] exp_q [$];

  always #5 clk = ~clk;

  mem_burst_ctrl #(.DATA_W(8), .ADDR_W(6), .BLEN_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .wr_rd(wr_rd), .addr(addr), .burst_len(burst_len),
    .data_valid(data_valid), .data_in(data_in), .data_out(data_out),
    .rd_valid(rd_valid),
`ifdef MEM_BURST_PARITY_EN
    .par_inj(par_inj), .par_err(par_err),
`endif
    .busy(busy)
  );

`ifndef MEM_BURST_PARITY_EN
  assign par_err = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check each read beat against the queued expectation.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("rd_extra", 1, 0);
      else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("rd_data", {24'd0, data_out}, {24'd0, e[7:0]});
`ifdef MEM_BURST_PARITY_EN
        chk("par_err", {31'd0, par_err}, {31'd0, e[8]});
`endif
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (req_ready !== 1'b1) chk("ready_timeout", 0, 1);
  endtask

  task automatic do_write(input logic [5:0] a, input int len, input logic [7:0] base, input int gap);
    wait_ready();
    req_valid = 1'b1; wr_rd = 1'b1; addr = a; burst_len = len[3:0];
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wr_busy", {31'd0, busy}, 1);
    for (int i = 0; i <= len; i++) begin
      logic [5:0] ad;
      ad = a + i[5:0];
      if (i == gap) begin
        data_valid = 1'b0;
        @(posedge clk); #1;
        chk("gap_busy", {31'd0, busy}, 1);
      end
      data_valid = 1'b1; data_in = base + i[7:0];
      @(posedge clk); #1;
      model_mem[ad] = base + i[7:0];
      model_pe[ad]  = par_inj;
    end
    data_valid = 1'b0;
    chk("wr_done_busy", {31'd0, busy}, 0);
    chk("wr_done_ready", {31'd0, req_ready}, 1);
  endtask

  task automatic do_read(input logic [5:0] a, input int len);
    wait_ready();
    req_valid = 1'b1; wr_rd = 1'b0; addr = a; burst_len = len[3:0];
    for (int i = 0; i <= len; i++) begin
      logic [5:0] ad;
      ad = a + i[5:0];
      exp_q.push_back({model_pe[ad], model_mem[ad]});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rd_lat0", {31'd0, rd_valid}, 0);
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      chk("rd_vld", {31'd0, rd_valid}, 1);
    end
    @(negedge clk);
    chk("rd_end", {31'd0, rd_valid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      model_mem[i] = 8'h00; model_pe[i] = 1'b0;
    end
    rst = 1'b0; req_valid = 1'b0; wr_rd = 1'b0; addr = '0; burst_len = '0;
    data_valid = 1'b0; data_in = '0; par_inj = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rdv", {31'd0, rd_valid}, 0);
    chk("rst_dout", {24'd0, data_out}, 0);
    rst = 1'b1;

    // First accept on the first edge after reset release, with a data gap.
    do_write(6'h05, 3, 8'hA1, 2);
    do_read(6'h05, 3);

    // Address wrap across the top of the array.
    do_write(6'h3E, 3, 8'h11, -1);
    do_read(6'h3E, 3);

    // Reset during beat 2 of a len=7 write over a known background.
    do_write(6'h20, 7, 8'hC0, -1);
    wait_ready();
    req_valid = 1'b1; wr_rd = 1'b1; addr = 6'h20; burst_len = 4'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      data_valid = 1'b1; data_in = 8'hD0 + i[7:0];
      @(posedge clk); #1;
      model_mem[6'h20 + i[5:0]] = 8'hD0 + i[7:0];
    end
    data_valid = 1'b1; data_in = 8'hD2;
    #2 rst = 1'b0;
    #1;
    chk("arst_ready", {31'd0, req_ready}, 1);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_rdv", {31'd0, rd_valid}, 0);
    chk("arst_dout", {24'd0, data_out}, 0);
    @(posedge clk); #1;
    data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_read(6'h20, 7);

    // req_valid held across a read: the second burst is taken only in the idle gap.
    wait_ready();
    req_valid = 1'b1; wr_rd = 1'b0; addr = 6'h05; burst_len = 4'd1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({model_pe[5], model_mem[5]});
      exp_q.push_back({model_pe[6], model_mem[6]});
    end
    @(posedge clk); #1;
    chk("b2b_e0_ready", {31'd0, req_ready}, 0);
    @(posedge clk); #1;
    chk("b2b_e1_ready", {31'd0, req_ready}, 0);
    @(posedge clk); #1;
    chk("b2b_idle_ready", {31'd0, req_ready}, 1);
    @(posedge clk); #1;
    chk("b2b_second_busy", {31'd0, busy}, 1);
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

`ifdef MEM_BURST_PARITY_EN
    par_inj = 1'b1;
    do_write(6'h30, 0, 8'h5A, -1);
    par_inj = 1'b0;
    do_write(6'h31, 0, 8'h5A, -1);
    do_read(6'h30, 1);
`endif

    repeat (3) @(posedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
